// File: rtl/axil_axis_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : axil_axis_fifo_ctrl
// Brief  : AXI4-Lite register front end that queues channel-tagged control
//          words into a FIFO draining to an AXI-Stream master port.
// Rev    : 1.0  initial release
// ============================================================================
module axil_axis_fifo_ctrl #(
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int AXI_ADDR_WIDTH = 10,
  parameter  int FIFO_DEPTH     = 16,
  parameter  int NUM_CHANNELS   = 4,
  localparam int c_TDW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [c_TDW-1:0]          m_axis_tdest,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_EW = c_TDW + AXI_DATA_WIDTH;

  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;
  localparam logic [1:0] c_DECERR = 2'b11;

  localparam logic [AXI_ADDR_WIDTH-1:0] c_ADDR_STATUS  = AXI_ADDR_WIDTH'(32'h100);
  localparam logic [AXI_ADDR_WIDTH-1:0] c_ADDR_CONTROL = AXI_ADDR_WIDTH'(32'h104);
  localparam logic [AXI_ADDR_WIDTH-1:0] c_ADDR_DEPTH   = AXI_ADDR_WIDTH'(32'h108);
  localparam logic [c_CW-1:0]           c_FULL_COUNT   = c_CW'(FIFO_DEPTH);
  localparam logic [6:0]                c_NUM_CH       = 7'(NUM_CHANNELS);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                      r_aw_held;
  logic                      r_w_held;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic                      r_rvalid;
  logic [1:0]                r_rresp;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic [c_EW-1:0]           r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]           r_wr_ptr;
  logic [c_PW-1:0]           r_rd_ptr;
  logic [c_CW-1:0]           r_count;
  logic                      r_ovf;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_flush;
  logic                      w_set_ovf;
  logic                      w_clr_ovf;
  logic [1:0]                w_bresp_nxt;
  logic [AXI_ADDR_WIDTH-1:0] w_waddr;
  logic [AXI_ADDR_WIDTH-1:0] w_raddr;
  logic [5:0]                w_ch;
  logic                      w_ch_ok;
  logic [c_EW-1:0]           w_head;
  logic [AXI_DATA_WIDTH-1:0] w_status;
  logic [AXI_DATA_WIDTH-1:0] w_rdata_nxt;
  logic [1:0]                w_rresp_nxt;
  logic                      w_unused;

  // Registers are word-addressed; byte-lane bits never select anything.
  assign w_waddr  = {r_awaddr[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign w_raddr  = {s_axi_araddr[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign w_unused = &{1'b0, r_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ~r_aw_held;
  assign s_axi_wready  = ~r_w_held;
  assign s_axi_arready = (r_rstate == R_IDLE);
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  assign w_aw_hs = s_axi_awvalid & ~r_aw_held;
  assign w_w_hs  = s_axi_wvalid & ~r_w_held;
  assign w_ar_hs = s_axi_arvalid & (r_rstate == R_IDLE);

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL_COUNT);
  assign w_pop    = m_axis_tvalid & m_axis_tready;
  assign w_ch     = r_awaddr[7:2];
  assign w_ch_ok  = ({1'b0, w_ch} < c_NUM_CH);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_status = AXI_DATA_WIDTH'({13'd0, r_ovf, w_empty, w_full, 16'(r_count)});

  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = m_axis_tvalid ? w_head[AXI_DATA_WIDTH-1:0] : '0;
  assign m_axis_tdest  = m_axis_tvalid ? w_head[c_EW-1:AXI_DATA_WIDTH] : '0;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_set_ovf    = 1'b0;
    w_clr_ovf    = 1'b0;
    w_bresp_nxt  = c_DECERR;
    case (r_wstate)
      W_IDLE: begin
        if ((r_aw_held | s_axi_awvalid) && (r_w_held | s_axi_wvalid)) begin
          w_wstate_nxt = W_EXEC;
        end
      end
      W_EXEC: begin
        w_wstate_nxt = W_RESP;
        if (r_awaddr[AXI_ADDR_WIDTH-1:8] == '0) begin
          if (w_ch_ok) begin
            // Fullness is judged on the pre-edge count, ignoring any concurrent pop.
            if (w_full) begin
              w_set_ovf   = 1'b1;
              w_bresp_nxt = c_SLVERR;
            end else begin
              w_push      = 1'b1;
              w_bresp_nxt = c_OKAY;
            end
          end
        end else if (w_waddr == c_ADDR_CONTROL) begin
          w_flush     = r_wdata[0];
          w_clr_ovf   = r_wdata[1];
          w_bresp_nxt = c_OKAY;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
      end
      if (r_wstate == W_EXEC) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp_nxt;
      end else if ((r_wstate == W_RESP) && s_axi_bready) begin
        r_bvalid  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rdata_nxt  = '0;
    w_rresp_nxt  = c_DECERR;
    case (r_rstate)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          w_rstate_nxt = R_RESP;
        end
        if (w_raddr == c_ADDR_STATUS) begin
          w_rdata_nxt = w_status;
          w_rresp_nxt = c_OKAY;
        end else if (w_raddr == c_ADDR_DEPTH) begin
          w_rdata_nxt = AXI_DATA_WIDTH'(FIFO_DEPTH);
          w_rresp_nxt = c_OKAY;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata_nxt;
      r_rresp  <= w_rresp_nxt;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------- FIFO
  always_ff @(posedge s_axi_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_ch[c_TDW-1:0], r_wdata};
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_ovf <= 1'b0;
    end else if (w_set_ovf) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire
